// File: rtl/cplx_wsum_pkg.sv
// Shared widths, FSM state type and the round/saturate helper for cplx_wsum.
package cplx_wsum_pkg;

    localparam int DW        = 12;           // sample width (signed)
    localparam int WW        = 4;            // weight width (signed)
    localparam int OW        = 9;            // output width (signed)
    localparam int AW        = 21;           // accumulator width
    localparam int SHIFT     = 10;           // right shift before saturation
    localparam int BURST_LEN = 12;           // samples per burst
    localparam int NUM_BURST = 10;           // bursts per run

    localparam int PW     = DW + WW;                // product width
    localparam int CNT_W  = $clog2(BURST_LEN);      // sample counter width
    localparam int BCNT_W = $clog2(NUM_BURST);      // burst counter width

    // Half an output LSB, added before the arithmetic shift.
    localparam logic signed [AW:0] RND     = (AW+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = (AW+1)'(-(2 ** (OW - 1)));

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Round half toward +inf, arithmetic shift, then clamp to the OW range.
    // One guard bit on top of AW keeps the rounding add from wrapping.
    function automatic logic [OW-1:0] sat_round(input logic signed [AW-1:0] acc);
        logic signed [AW:0] w_ext;
        logic signed [AW:0] w_shr;
        logic [OW-1:0]      w_res;
        w_ext = (AW+1)'(acc) + RND;
        w_shr = w_ext >>> SHIFT;
        if (w_shr > SAT_MAX) begin
            w_res = OW'(SAT_MAX);
        end else if (w_shr < SAT_MIN) begin
            w_res = OW'(SAT_MIN);
        end else begin
            w_res = OW'(w_shr);
        end
        return w_res;
    endfunction

endpackage

// File: rtl/cplx_wsum_cmac_lane.sv
// One component (re or im) of the complex MAC: P1 registers the two partial
// products, P2 combines them (a*b +/- c*d) and accumulates over a burst.
module cmac_lane
    import cplx_wsum_pkg::*;
#(
    parameter bit SUB = 1'b0              // 1: a*b - c*d, 0: a*b + c*d
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,        // operands below are meaningful
    input  logic [DW-1:0] i_a,
    input  logic [WW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    input  logic [WW-1:0] i_d,
    input  logic          i_p1_valid,     // P1 products hold a live sample
    input  logic          i_p1_first,     // that sample opens a burst
    output logic [AW-1:0] o_acc
);

    logic signed [PW-1:0] w_prod0;
    logic signed [PW-1:0] w_prod1;
    logic signed [PW-1:0] r_p0;
    logic signed [PW-1:0] r_p1;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] r_acc;

    // Sign-extend both operands to the product width so the low PW bits
    // of the multiply are the exact signed product.
    assign w_prod0 = PW'($signed(i_a)) * PW'($signed(i_b));
    assign w_prod1 = PW'($signed(i_c)) * PW'($signed(i_d));

    // The sum needs PW+1 bits; AW is wider, so sign-extend first, then combine.
    assign w_sum = SUB ? (AW'(r_p0) - AW'(r_p1)) : (AW'(r_p0) + AW'(r_p1));

    // P1: capture products only for live samples so idle-cycle data never enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0 <= '0;
            r_p1 <= '0;
        end else if (i_valid) begin
            r_p0 <= w_prod0;
            r_p1 <= w_prod1;
        end
    end

    // P2: the first sample of a burst loads, later samples add, gaps hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_p1_valid) begin
            if (i_p1_first) begin
                r_acc <= w_sum;
            end else begin
                r_acc <= r_acc + w_sum;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cplx_wsum.sv
// Complex weighted sum over fixed-length bursts with round/saturate output.
// Pipeline: S0 input capture, P1 products, P2 accumulate, P3 round/saturate.
// Handshake: in_en qualifies one sample per clock (no backpressure);
// out_en is a one-cycle valid for out_data_i/q, which hold between pulses.
module cplx_wsum
    import cplx_wsum_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data_i,
    input  logic [DW-1:0] in_data_q,
    input  logic [WW-1:0] in_w_i,
    input  logic [WW-1:0] in_w_q,
    input  logic          in_en,
    output logic [OW-1:0] out_data_i,
    output logic [OW-1:0] out_data_q,
    output logic          out_en,
    output logic          out_done,
    output logic [1:0]    out_dbg_state
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_done_nxt;
    logic               w_first;
    logic               w_last;
    logic               w_final;

    logic [CNT_W-1:0]   r_cnt;
    logic [BCNT_W-1:0]  r_bcnt;

    // S0 registers: qualified input sample and its framing flags
    logic               r_s_valid;
    logic               r_s_first;
    logic               r_s_last;
    logic [DW-1:0]      r_s_di;
    logic [DW-1:0]      r_s_dq;
    logic [WW-1:0]      r_s_wi;
    logic [WW-1:0]      r_s_wq;

    // P1 / P2 control flags travelling alongside the lanes
    logic               r_p1_valid;
    logic               r_p1_first;
    logic               r_p1_last;
    logic               r_p2_valid;

    logic [AW-1:0]      w_acc_i;
    logic [AW-1:0]      w_acc_q;

    logic [OW-1:0]      r_out_i;
    logic [OW-1:0]      r_out_q;
    logic               r_out_en;
    logic               r_out_done;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_final = w_last && (r_bcnt == BCNT_W'(NUM_BURST - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: accept in RUN only; FLUSH waits for the final result.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_accept = in_en;
                if (in_en && w_final) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Previous bursts' results have long drained, so this is the last one.
                if (r_out_en) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Sample and burst counters; framing is purely by count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bcnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= '0;
                if (w_final) begin
                    r_bcnt <= '0;
                end else begin
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // S0: register accepted samples with their first/last flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_first <= 1'b0;
            r_s_last  <= 1'b0;
            r_s_di    <= '0;
            r_s_dq    <= '0;
            r_s_wi    <= '0;
            r_s_wq    <= '0;
        end else begin
            r_s_valid <= w_accept;
            r_s_first <= w_accept && w_first;
            r_s_last  <= w_accept && w_last;
            if (w_accept) begin
                r_s_di <= in_data_i;
                r_s_dq <= in_data_q;
                r_s_wi <= in_w_i;
                r_s_wq <= in_w_q;
            end
        end
    end

    // P1/P2 control: flags follow the products, then only the last sample
    // of a burst arms the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p2_valid <= 1'b0;
        end else begin
            r_p1_valid <= r_s_valid;
            r_p1_first <= r_s_first;
            r_p1_last  <= r_s_last;
            r_p2_valid <= r_p1_valid && r_p1_last;
        end
    end

    // re = di*wi - dq*wq
    cmac_lane #(.SUB(1'b1)) u_lane_re (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (r_s_valid),
        .i_a        (r_s_di),
        .i_b        (r_s_wi),
        .i_c        (r_s_dq),
        .i_d        (r_s_wq),
        .i_p1_valid (r_p1_valid),
        .i_p1_first (r_p1_first),
        .o_acc      (w_acc_i)
    );

    // im = di*wq + dq*wi
    cmac_lane #(.SUB(1'b0)) u_lane_im (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (r_s_valid),
        .i_a        (r_s_di),
        .i_b        (r_s_wq),
        .i_c        (r_s_dq),
        .i_d        (r_s_wi),
        .i_p1_valid (r_p1_valid),
        .i_p1_first (r_p1_first),
        .o_acc      (w_acc_q)
    );

    // P3: round/saturate the finished burst; data holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_i    <= '0;
            r_out_q    <= '0;
            r_out_en   <= 1'b0;
            r_out_done <= 1'b0;
        end else begin
            r_out_en   <= r_p2_valid;
            r_out_done <= w_done_nxt;
            if (r_p2_valid) begin
                r_out_i <= sat_round($signed(w_acc_i));
                r_out_q <= sat_round($signed(w_acc_q));
            end
        end
    end

    assign out_data_i    = r_out_i;
    assign out_data_q    = r_out_q;
    assign out_en        = r_out_en;
    assign out_done      = r_out_done;
    assign out_dbg_state = r_state;

endmodule

// File: tb/tb_cplx_wsum.sv
// Directed bench for cplx_wsum: drivers push hand-computed results into a
// scoreboard queue, a negedge monitor pops and compares on every out_en.
module tb_cplx_wsum;
  import cplx_wsum_pkg::*;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   in_data_i;
  logic [11:0]   in_data_q;
  logic [3:0]    in_w_i;
  logic [3:0]    in_w_q;
  logic          in_en;
  logic [8:0]    out_data_i;
  logic [8:0]    out_data_q;
  logic          out_en;
  logic          out_done;
  logic [1:0]    out_dbg_state;

  always #5 clk = ~clk;

  cplx_wsum dut (
    .clk           (clk),
    .rst           (rst),
    .in_data_i     (in_data_i),
    .in_data_q     (in_data_q),
    .in_w_i        (in_w_i),
    .in_w_q        (in_w_q),
    .in_en         (in_en),
    .out_data_i    (out_data_i),
    .out_data_q    (out_data_q),
    .out_en        (out_en),
    .out_done      (out_done),
    .out_dbg_state (out_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  time         exp_t_q[$];
  int          n_out = 0;
  int          done_cnt = 0;
  bit          prev_en = 1'b0;

  int bd_i[12];
  int bd_q[12];
  int bw_i[12];
  int bw_q[12];

  function automatic logic [17:0] pack(input int vi, input int vq);
    logic [31:0] a;
    logic [31:0] b;
    a = vi;
    b = vq;
    return {a[8:0], b[8:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input int di, input int dq, input int wi, input int wq);
    @(negedge clk);
    in_en     = 1'b1;
    in_data_i = 12'(di);
    in_data_q = 12'(dq);
    in_w_i    = 4'(wi);
    in_w_q    = 4'(wq);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_en     = 1'b0;
      in_data_i = 'x;
      in_data_q = 'x;
      in_w_i    = 'x;
      in_w_q    = 'x;
    end
  endtask

  task automatic fill_const(input int di, input int dq, input int wi, input int wq);
    for (int k = 0; k < 12; k++) begin
      bd_i[k] = di; bd_q[k] = dq; bw_i[k] = wi; bw_q[k] = wq;
    end
  endtask

  task automatic fill_single(input int pos, input int di, input int dq, input int wi, input int wq);
    for (int k = 0; k < 12; k++) begin
      bd_i[k] = 0; bd_q[k] = 0; bw_i[k] = 0; bw_q[k] = 0;
    end
    bd_i[pos] = di; bd_q[pos] = dq; bw_i[pos] = wi; bw_q[pos] = wq;
  endtask

  // Last sample is sampled 5 later (posedge); result visible at negedge 3.5 cycles after that.
  task automatic run_burst(input int gap, input logic [17:0] exp, input bit expect_out);
    for (int k = 0; k < 12; k++) begin
      drive_sample(bd_i[k], bd_q[k], bw_i[k], bw_q[k]);
      if (k == 11) begin
        if (expect_out) begin
          exp_q.push_back(exp);
          exp_t_q.push_back($time + 40);
        end
      end else if (gap > 0) begin
        idle(gap);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL done_count got=%0d want=1", done_cnt);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (rst) begin
      n_out   = 0;
      prev_en = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    time         t;
    if (!rst) begin
      if (out_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_en got i=%0d q=%0d want=no_output",
                   $signed(out_data_i), $signed(out_data_q));
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          if ({out_data_i, out_data_q} != e) begin
            failures++;
            $display("FAIL result got i=%0d q=%0d want i=%0d q=%0d",
                     $signed(out_data_i), $signed(out_data_q),
                     $signed(e[17:9]), $signed(e[8:0]));
          end
          checks++;
          if ($time != t) begin
            failures++;
            $display("FAIL latency got_t=%0t want_t=%0t", $time, t);
          end
        end
        n_out++;
      end
      if (out_done) begin
        checks++;
        if (!(prev_en && !out_en && n_out == NUM_BURST)) begin
          failures++;
          $display("FAIL out_done_timing got prev_en=%0d en=%0d n_out=%0d want 1 0 %0d",
                   prev_en, out_en, n_out, NUM_BURST);
        end
        done_cnt++;
      end
      prev_en = out_en;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in_en = 1'b0;
    in_data_i = '0; in_data_q = '0; in_w_i = '0; in_w_q = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_out_i", int'(out_data_i), 0);
    check_val("rst_out_q", int'(out_data_q), 0);
    check_val("rst_out_en", int'(out_en), 0);
    check_val("rst_out_done", int'(out_done), 0);
    check_val("rst_state", int'(out_dbg_state), int'(ST_RUN));

    // Run A: ten directed bursts.
    fill_const(2047, 0, 7, 0);          run_burst(0, pack(168, 0), 1'b1);
    fill_const(-2048, -2048, -8, 7);    run_burst(0, pack(255, 24), 1'b1);
    fill_const(2047, 2047, -8, 7);      run_burst(0, pack(-256, -24), 1'b1);
    fill_single(5, 512, 512, 1, 0);     run_burst(0, pack(1, 1), 1'b1);
    fill_single(5, 511, 0, 1, 0);       run_burst(0, pack(0, 0), 1'b1);
    fill_single(5, -512, -512, 1, 0);   run_burst(0, pack(0, 0), 1'b1);
    fill_single(5, -513, 0, 1, 0);      run_burst(0, pack(-1, 0), 1'b1);
    fill_const(1000, 500, -3, 5);       run_burst(0, pack(-64, 41), 1'b1);
    fill_const(-700, 300, 4, -2);       run_burst(3, pack(-26, 30), 1'b1);
    fill_const(2047, -2048, -8, -8);    run_burst(3, pack(-256, 0), 1'b1);
    idle(1);
    wait_done(40);
    drain(20);
    idle(2);
    check_val("state_done", int'(out_dbg_state), int'(ST_DONE));

    // 11th burst after the run completes: must be ignored.
    fill_const(2047, 0, 7, 0);          run_burst(0, '0, 1'b0);
    idle(20);
    check_val("done_once_a", done_cnt, 1);

    // Run B: restart, two bursts, abort burst 3 mid-way with reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    check_val("restart_state", int'(out_dbg_state), int'(ST_RUN));
    fill_const(300, -200, 2, 3);
    run_burst(3, pack(14, 6), 1'b1);
    run_burst(3, pack(14, 6), 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive_sample(2047, 2047, 7, 7);
      idle(3);
    end
    // Reset cycle with a simultaneous sample, which must be dropped.
    @(negedge clk);
    rst = 1'b1;
    in_en = 1'b1;
    in_data_i = 12'h7ff; in_data_q = 12'h7ff; in_w_i = 4'h7; in_w_q = 4'h7;
    @(negedge clk);
    rst = 1'b0;
    in_en = 1'b0;
    check_val("midrst_out_i", int'(out_data_i), 0);
    check_val("midrst_out_q", int'(out_data_q), 0);
    check_val("midrst_done_cnt", done_cnt, 0);
    for (int b = 0; b < NUM_BURST; b++) begin
      run_burst(3, pack(14, 6), 1'b1);
    end
    idle(1);
    wait_done(40);
    drain(20);
    idle(5);
    check_val("done_once_b", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cplx_wsum.md
Name: cplx_wsum

Overview:
- Device under test driven by the signal generator. Consumes bursts of 12-bit complex samples with 4-bit complex weights (in_en qualified).
- Per burst, accumulates the complex weighted sum, then rounds and saturates it to 9-bit I/Q.
- Emits one out_en-qualified result per burst. Pulses out_done after the final burst of a run.

Parameters:
- DW, 12, data width, signed two's complement.
- WW, 4, weight width, signed two's complement.
- OW, 9, output width, signed.
- AW, 21, accumulator width. Must be >= DW+WW+1+ceil(log2(BURST_LEN)).
- BURST_LEN, 12, samples per burst.
- NUM_BURST, 10, bursts per run.
- SHIFT, 10, right shift applied before saturation. Must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data_i  in  DW  sample real part.
- in_data_q  in  DW  sample imaginary part.
- in_w_i  in  WW  weight real part.
- in_w_q  in  WW  weight imaginary part.
- in_en  in  1  sample valid; one sample per clk while high.
- out_data_i  out  OW  result real part.
- out_data_q  out  OW  result imaginary part.
- out_en  out  1  result valid, one-cycle pulse.
- out_done  out  1  run complete, one-cycle pulse.

Behaviour:
- Reset: out_data_i/q=0, out_en=0, out_done=0. Sample count, burst count, pipeline valids and accumulators are cleared. FSM goes to RUN.
- Reset mid-operation: any partial burst and in-flight pipeline contents are discarded. No out_en is produced for them.
- Math, signed throughout:
  - re = di*wi - dq*wq
  - im = di*wq + dq*wi
  - Products are DW+WW bits; each sum/difference is DW+WW+1 bits, sign-extended to AW.
- Pipeline stage P1: register the four products, plus valid, first-sample flag and last-sample flag.
- Pipeline stage P2: if first, acc <= sum; else acc <= acc + sum. Applies to acc_i and acc_q independently.
- Pipeline stage P3, only on the last sample:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf, arithmetic shift.
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1], i.e. [-256, 255].
  - Register r on out_data_i/q, with out_en=1 for one cycle.
- Latency: out_en is high in the cycle following the 3rd rising edge after the edge that samples the last in_en of a burst.
- out_data_i/q hold their last value between pulses.
- Burst framing is by count only:
  - A sample counter 0..BURST_LEN-1 increments on each in_en cycle.
  - count==0 marks the first sample; count==BURST_LEN-1 marks the last sample and wraps the counter to 0.
  - in_en gaps inside a burst are allowed; the accumulator simply holds.
  - Back-to-back bursts with zero gap are supported, because the first sample loads rather than adds.
- FSM states: RUN, FLUSH, DONE.
  - RUN: accept samples. The last sample of burst NUM_BURST moves the FSM to FLUSH.
  - FLUSH: in_en ignored. Wait for that burst's out_en; on the following cycle pulse out_done=1 and move to DONE.
  - DONE: in_en ignored, out_en=0, out_done=0. Leave only via rst.
- out_done is exactly one cycle, one cycle after the final out_en. It is never asserted together with out_en.
- Simultaneous rst and in_en: rst wins; the sample is dropped.
- X on the data inputs while in_en=0 must not propagate to the accumulators or outputs.

Decomposition:
- Package cplx_wsum_pkg holds:
  - width constants (DW, WW, OW, AW, SHIFT);
  - the FSM state enum (RUN, FLUSH, DONE);
  - a function sat_round(acc) returning OW bits.
- One natural sub-module, cmac_lane: the P1/P2 product-sum and accumulator for one complex component. It is instantiated twice, once for re and once for im (sign and operand selection as parameters).
- FSM, counters and P3 live in the top.

Test Plan:
- Basic burst, 12 samples of di=2047, dq=0, wi=7, wq=0 -> one out_en, 3 cycles after the last sample edge, with out_data_i=168 (171948 rounded >>10) and out_data_q=0.
- Positive saturation, 12 samples of di=-2048, dq=-2048, wi=-8, wq=7 -> out_data_i=255 (unsaturated 360) and out_data_q=24 (24576+512>>10).
- Negative saturation and rounding:
  - 12 samples of di=2047, dq=2047, wi=-8, wq=7 -> out_data_i=-256.
  - A burst whose single non-zero sample is di=512, wi=1 (acc=512) -> out_data_i=1. With acc=511 -> 0. With acc=-512 -> 0.
- Framing: two bursts back-to-back with zero gap, the second containing 3-cycle in_en gaps -> two independent, correct results with no carry-over between bursts.
- Full run: 10 bursts of 12 samples with 3-cycle gaps -> exactly 10 out_en pulses. out_done pulses once, one cycle after the 10th out_en. An 11th burst driven afterwards produces no out_en.
- Reset: assert rst for 1 cycle after the 6th sample of burst 3, then send 12 fresh samples -> no output for the aborted burst, and the next result reflects only the fresh samples. The burst count restarts, so 10 further bursts are needed for out_done.
